mul_arbiter: RTL
================

# mul_arbiter

Shares one sequential 8-bit `multiplier` instance between two requesters, such as the ALU control path and a second client. Each requester has a valid/ready request channel and a valid/ready response channel. The block performs round-robin arbitration, drives the multiplier's `start`/operand inputs, waits for `done`, and returns the product to the requester that owns the operation. Exactly one multiplication is in flight at any time.

## Interface

Parameters:
- `WIDTH`, default 8: operand width. The product is `2*WIDTH` bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  in  WIDTH each  requester 0 operands (multiplier, multiplicand).
- `resp0_valid`  out  1  product for requester 0 available.
- `resp0_ready`  in  1  requester 0 accepts the product.
- `resp0_product`  out  2*WIDTH  product for requester 0.
- `req1_*`, `resp1_*`: identical set for requester 1.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_multiplier`, `mul_multiplicand`  out  WIDTH each  registered operands to the multiplier.
- `mul_product`  in  2*WIDTH  multiplier result.
- `mul_done`  in  1  multiplier completion.
- `busy`  out  1  high in every state except IDLE.

## Operation

- FSM states and transitions:
  - IDLE: if any `reqN_valid`, grant one requester and go to START.
  - START: go to WAIT.
  - WAIT: go to RESP on qualified `mul_done`.
  - RESP: go to IDLE when the owner's `respN_ready` is high.
- Arbitration happens only in IDLE.
  - A 1-bit priority pointer `prio` resets to 0.
  - If only one requester is valid, it wins.
  - If both are valid, requester `prio` wins.
  - After every grant, `prio` is set to the non-granted index, so simultaneous requests alternate.
- Grant:
  - `reqN_ready` is combinational, high only in IDLE, only for the winner.
  - On that edge the block latches the operands into `mul_multiplier`/`mul_multiplicand` and records the owner index.
- `mul_start` is high for exactly the START cycle. Operands are held stable from START until the next grant.
- WAIT:
  - `mul_done` is ignored during the first WAIT cycle, which guards against a stale `done` from the previous operation.
  - From the second WAIT cycle onward, the first cycle with `mul_done` high captures `mul_product` into the result register.
- RESP:
  - The owner's `respN_valid` is high and `respN_product` shows the result register. The other requester's `resp_valid` stays 0.
  - Both `respN_product` outputs show the result register; only the matching `valid` qualifies it.
  - The result is held indefinitely until `respN_ready`; backpressure stalls the multiplier.
- The block does not check for or handle a non-owner's `resp_ready`. Requests arriving while `busy` simply wait; they are never dropped.
- Arithmetic is done by the multiplier and is unsigned. This block never alters the operands or the product.

## Timing

- Reset values (asynchronous, immediate):
  - State = IDLE, `prio` = 0, owner = 0.
  - `mul_start` = 0, `busy` = 0, operand registers = 0, result register = 0.
  - All `resp_valid` = 0; all `req_ready` = 0 while `rst` is high.
- Latency:
  - Grant edge to `mul_start` high: 1 cycle (START).
  - `mul_done` edge to `respN_valid`: 1 cycle.
  - Total = 3 + multiplier latency, with zero backpressure.
- Throughput: at minimum one IDLE cycle separates operations. Response acceptance edge → IDLE, with the next grant possible in that IDLE cycle.
- If reset is asserted mid-operation (any state), the block returns to IDLE. The in-flight result is discarded and no `resp_valid` pulse is produced. The multiplier shares `rst`.
- A requester that drops `req_valid` before being granted is legal; no grant is issued for it.

## Test plan

- Single request: `req0` a=170, b=85 → exactly one `mul_start` pulse, `resp0_valid` with `resp0_product`=14450, `resp1_valid` stays 0, `busy` falls after acceptance.
- Simultaneous requests after reset: `req0`=123×45 and `req1`=128×128 in the same cycle → requester 0 is served first (5535), then requester 1 (16384). No overlap of `mul_start` and at most one `resp_valid` high at a time.
- Fairness: both requesters hold `valid` continuously for 4 operations → grants alternate 0,1,0,1 and every product is correct (include 255×255=65025 and 0×0=0).
- Backpressure: hold `resp1_ready`=0 for 20 cycles → `resp1_valid` and `resp1_product` stay constant, no new `mul_start` occurs, and a pending `req0` gets no `ready` until `resp1_ready` rises.
- Stale done: the multiplier model holds `done` high across a new `start` → the first WAIT cycle is ignored and the correct new product is returned.
- Reset mid-operation: assert `rst` during WAIT → all outputs are at reset values immediately, no response is issued, and the next request (7×3) returns 21 with `prio` back at 0.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between two requesters.
// One operation in flight; the product is held for its owner until accepted.
module mul_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               resp0_valid,
    input  logic               resp0_ready,
    output logic [2*WIDTH-1:0] resp0_product,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               resp1_valid,
    input  logic               resp1_ready,
    output logic [2*WIDTH-1:0] resp1_product,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_multiplier,
    output logic [WIDTH-1:0]   mul_multiplicand,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_done,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t             state, state_nx;
    logic               prio;
    logic               owner;
    logic               first_wait;
    logic [2*WIDTH-1:0] result;
    logic               gnt0, gnt1;
    logic               resp_ack;

    always_comb begin
        state_nx    = state;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        mul_start   = 1'b0;
        busy        = 1'b1;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        resp_ack    = owner ? resp1_ready : resp0_ready;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // ready must stay low while reset is held, even with valid high
                if (!rst) begin
                    gnt0 = req0_valid && (!req1_valid || !prio);
                    gnt1 = req1_valid && (!req0_valid || prio);
                end
                if (gnt0 || gnt1)
                    state_nx = START;
            end
            START: begin
                mul_start = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                // the first WAIT cycle may still see done from the previous op
                if (!first_wait && mul_done)
                    state_nx = RESP;
            end
            RESP: begin
                resp0_valid = !owner;
                resp1_valid = owner;
                if (resp_ack)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            prio             <= 1'b0;
            owner            <= 1'b0;
            first_wait       <= 1'b0;
            result           <= '0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
        end else begin
            state <= state_nx;
            if (gnt0 || gnt1) begin
                owner            <= gnt1;
                prio             <= gnt0;
                mul_multiplier   <= gnt1 ? req1_a : req0_a;
                mul_multiplicand <= gnt1 ? req1_b : req0_b;
            end
            if (state == START)
                first_wait <= 1'b1;
            else if (state == WAIT)
                first_wait <= 1'b0;
            if (state == WAIT && !first_wait && mul_done)
                result <= mul_product;
        end
    end

    assign req0_ready    = gnt0;
    assign req1_ready    = gnt1;
    assign resp0_product = result;
    assign resp1_product = result;

endmodule
